// File: rtl/warp_pkg.sv
// Shared warp-accelerator types and defaults, including the memory arbiter's
// request record, FSM state encoding and round-robin pointer helper.
package warp_pkg;

    localparam int ADDR_WIDTH                      = 32;
    localparam int MEM_ARB_NUM_REQ_DEFAULT         = 4;
    localparam int MEM_ARB_MAX_OUTSTANDING_DEFAULT = 4;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  write;
        logic [31:0]           data;
    } mem_req_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    function automatic int rr_next(input int g, input int n);
        return (g + 1) % n;
    endfunction

endpackage

// File: rtl/warp_id_fifo.sv
// In-order FIFO of requester IDs; head is the owner of the oldest in-flight request.
module warp_id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_id,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WIDTH-1:0]             head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/rocc_mem_arbiter.sv
// Round-robin arbiter sharing the RoCC L1 memory port; responses are steered back
// in issue order. Define WARP_MEM_ARB_FETCH_PRIO_EN to give requester 0 priority.
module rocc_mem_arbiter #(
    parameter int NUM_REQ         = warp_pkg::MEM_ARB_NUM_REQ_DEFAULT,
    parameter int ADDR_WIDTH      = warp_pkg::ADDR_WIDTH,
    parameter int MAX_OUTSTANDING = warp_pkg::MEM_ARB_MAX_OUTSTANDING_DEFAULT
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]         req_addr,
    input  logic [NUM_REQ-1:0]                    req_write,
    input  logic [NUM_REQ*32-1:0]                 req_wdata,
    output logic [NUM_REQ-1:0]                    resp_valid,
    output logic [31:0]                           resp_data,
    output logic                                  mem_req_valid,
    input  logic                                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0]                 mem_req_addr,
    output logic                                  mem_req_write,
    output logic [31:0]                           mem_req_data,
    input  logic                                  mem_resp_valid,
    output logic                                  mem_resp_ready,
    input  logic [31:0]                           mem_resp_data,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding,
    output logic                                  orphan_err
);
    import warp_pkg::*;

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e     state;
    arb_state_e     state_next;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] rr_ptr_next;
    logic [IDW-1:0] lock;
    logic [IDW-1:0] lock_next;
    logic [IDW-1:0] arb_idx;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] head;
    logic           arb_found;
    logic           out_en;
    logic           fifo_full;
    logic           fifo_empty;
    logic           xfer;
    logic           pop;

    // out_en keeps every request-side output low while reset is asserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            rr_ptr     <= '0;
            lock       <= '0;
            out_en     <= 1'b0;
            orphan_err <= 1'b0;
        end else begin
            state  <= state_next;
            rr_ptr <= rr_ptr_next;
            lock   <= lock_next;
            out_en <= 1'b1;
            if (mem_resp_valid && fifo_empty) orphan_err <= 1'b1;
        end
    end

    always_comb begin
        int idx;
        arb_found = 1'b0;
        arb_idx   = '0;
        idx       = 0;
`ifdef WARP_MEM_ARB_FETCH_PRIO_EN
        if (req_valid[0]) arb_found = 1'b1;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!arb_found && req_valid[IDW'(idx)]) begin
                arb_found = 1'b1;
                arb_idx   = IDW'(idx);
            end
        end
    end

    assign sel           = (state == ARB_HOLD) ? lock : arb_idx;
    assign mem_req_valid = out_en && ((state == ARB_HOLD) || (arb_found && !fifo_full));
    assign xfer          = mem_req_valid && mem_req_ready;
    assign pop           = mem_resp_valid && !fifo_empty;

    always_comb begin
        state_next  = state;
        rr_ptr_next = rr_ptr;
        lock_next   = lock;
        case (state)
            ARB_IDLE: begin
                if (mem_req_valid && !mem_req_ready) begin
                    state_next = ARB_HOLD;
                    lock_next  = sel;
                end
            end
            ARB_HOLD: begin
                if (mem_req_ready) state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
        if (xfer) begin
`ifdef WARP_MEM_ARB_FETCH_PRIO_EN
            if (sel != '0) rr_ptr_next = IDW'(rr_next(int'(sel), NUM_REQ));
`else
            rr_ptr_next = IDW'(rr_next(int'(sel), NUM_REQ));
`endif
        end
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        if (xfer) req_ready[sel] = 1'b1;
        if (pop)  resp_valid[head] = 1'b1;
    end

    assign mem_req_addr   = req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
    assign mem_req_write  = req_write[sel];
    assign mem_req_data   = req_wdata[sel*32 +: 32];
    assign mem_resp_ready = !fifo_empty;
    assign resp_data      = mem_resp_data;

    warp_id_fifo #(
        .WIDTH (IDW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (xfer),
        .push_id (sel),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (outstanding),
        .head    (head)
    );

endmodule

// File: tb/tb_rocc_mem_arbiter.sv
// Directed bench for rocc_mem_arbiter: fairness, backpressure lock, FIFO full,
// push/pop overlap, orphan responses and mid-burst reset.
module tb_rocc_mem_arbiter;
    import warp_pkg::*;

    localparam int NR = 4;
    localparam int AW = warp_pkg::ADDR_WIDTH;
    localparam int MO = 4;
    localparam int CW = $clog2(MO + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR-1:0]     req_write = 4'b0101;
    logic [NR*32-1:0]  req_wdata = '0;
    logic [NR-1:0]     resp_valid;
    logic [31:0]       resp_data;
    logic              mem_req_valid;
    logic              mem_req_ready = 1'b0;
    logic [AW-1:0]     mem_req_addr;
    logic              mem_req_write;
    logic [31:0]       mem_req_data;
    logic              mem_resp_valid = 1'b0;
    logic              mem_resp_ready;
    logic [31:0]       mem_resp_data = '0;
    logic [CW-1:0]     outstanding;
    logic              orphan_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rocc_mem_arbiter #(
        .NUM_REQ         (NR),
        .ADDR_WIDTH      (AW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_write      (req_write),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_write  (mem_req_write),
        .mem_req_data   (mem_req_data),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_ready (mem_resp_ready),
        .mem_resp_data  (mem_resp_data),
        .outstanding    (outstanding),
        .orphan_err     (orphan_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NR-1:0] oh(input int g);
        return NR'(1) << g;
    endfunction

`ifdef WARP_MEM_ARB_FETCH_PRIO_EN
    int exp_grant[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
    int exp_grant[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif

    initial begin
        logic [NR-1:0] wr_pat;
        wr_pat = 4'b0101;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = AW'(32'h1000 + 16 * i);
            req_wdata[i*32 +: 32] = 32'hA0 + i;
        end

        // reset state
        #1;
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_mem_resp_ready", mem_resp_ready, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_orphan", orphan_err, 0);
        step();
        rst_n = 1'b1;
        step();

        // fairness with responses two cycles after issue
        for (int c = 0; c < 10; c++) begin
            req_valid      = (c < 8) ? 4'hF : 4'h0;
            mem_req_ready  = 1'b1;
            mem_resp_valid = (c >= 2);
            mem_resp_data  = 32'hD000 + c;
            #1;
            check("fair_outst", outstanding, (c < 2) ? c : ((c <= 8) ? 2 : 1));
            if (c < 8) begin
                check("fair_req_ready", req_ready, oh(exp_grant[c]));
                check("fair_addr", mem_req_addr, 32'h1000 + 16 * exp_grant[c]);
                check("fair_wdata", mem_req_data, 32'hA0 + exp_grant[c]);
                check("fair_write", mem_req_write, wr_pat[exp_grant[c]]);
            end
            if (c >= 2) begin
                check("fair_resp_valid", resp_valid, oh(exp_grant[c-2]));
                check("fair_resp_data", resp_data, 32'hD000 + c);
            end
            step();
        end
        mem_resp_valid = 1'b0;
        #1;
        check("fair_drained", outstanding, 0);

        // backpressure: grant to 2 locked while 1 rises
        req_addr[2*AW +: AW] = AW'(32'h100);
        req_valid     = 4'b0100;
        mem_req_ready = 1'b0;
        #1;
        check("bp_valid", mem_req_valid, 1);
        check("bp_addr0", mem_req_addr, 32'h100);
        check("bp_ready0", req_ready, 0);
        step();
        req_valid = 4'b0110;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("bp_addr_held", mem_req_addr, 32'h100);
            check("bp_ready_low", req_ready, 0);
            check("bp_write_held", mem_req_write, 1);
            step();
        end
        mem_req_ready = 1'b1;
        #1;
        check("bp_ready_pulse", req_ready, 4'b0100);
        check("bp_addr_accept", mem_req_addr, 32'h100);
        step();
        req_valid = 4'b0010;
        #1;
        check("bp_next_grant", req_ready, 4'b0010);
        check("bp_next_addr", mem_req_addr, 32'h1010);
        step();
        req_valid      = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        #1;
        check("bp_outst", outstanding, 2);
        check("bp_resp_first", resp_valid, 4'b0100);
        step();
        #1;
        check("bp_resp_second", resp_valid, 4'b0010);
        step();
        mem_resp_valid = 1'b0;

        // fill the ID FIFO from requester 3
        req_valid     = 4'b1000;
        mem_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("full_outst_fill", outstanding, k);
            check("full_grant", req_ready, 4'b1000);
            step();
        end
        #1;
        check("full_outst4", outstanding, 4);
        check("full_blocked", mem_req_valid, 0);
        check("full_no_ready", req_ready, 0);
        step();
        mem_resp_valid = 1'b1;
        #1;
        check("full_no_bypass", mem_req_valid, 0);
        check("full_pop_owner", resp_valid, 4'b1000);
        check("full_resp_ready", mem_resp_ready, 1);
        step();
        mem_resp_valid = 1'b0;
        #1;
        check("full_outst3", outstanding, 3);
        check("full_reissue", req_ready, 4'b1000);
        step();
        req_valid = '0;
        #1;
        check("full_outst_back4", outstanding, 4);
        mem_resp_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("full_drain_owner", resp_valid, 4'b1000);
            step();
        end
        mem_resp_valid = 1'b0;
        #1;
        check("full_drained", outstanding, 0);

        // orphan response
        mem_resp_valid = 1'b1;
        #1;
        check("orph_no_resp", resp_valid, 0);
        check("orph_not_ready", mem_resp_ready, 0);
        step();
        mem_resp_valid = 1'b0;
        #1;
        check("orph_set", orphan_err, 1);
        step();
        check("orph_sticky", orphan_err, 1);

        // reset mid-burst, then late response
        req_valid     = 4'hF;
        mem_req_ready = 1'b1;
        step();
        step();
        #1;
        check("mid_outst_before", outstanding, 2);
        rst_n          = 1'b0;
        mem_resp_valid = 1'b1;
        #1;
        check("mid_rst_mem_req_valid", mem_req_valid, 0);
        check("mid_rst_req_ready", req_ready, 0);
        check("mid_rst_resp_valid", resp_valid, 0);
        check("mid_rst_mem_resp_ready", mem_resp_ready, 0);
        check("mid_rst_outst", outstanding, 0);
        check("mid_rst_orphan", orphan_err, 0);
        step();
        mem_resp_valid = 1'b0;
        req_valid      = '0;
        rst_n          = 1'b1;
        step();
        mem_resp_valid = 1'b1;
        #1;
        check("late_no_resp", resp_valid, 0);
        step();
        mem_resp_valid = 1'b0;
        #1;
        check("late_orphan", orphan_err, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
